// File: rtl/alu_dmem_opseg.sv
// Single-cycle datapath slice: 8-bit adder ALU feeding a 256x8 data memory,
// plus a 7-segment glyph decoder for the current opcode.
module alu_dmem_opseg (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    input  logic       aluOp,
    input  logic [7:0] writeData,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic [1:0] opcode,
    output logic [7:0] result,
    output logic [7:0] readData,
    output logic [6:0] seg
);

    logic [7:0] mem [256];
    logic [7:0] regSum;
    logic [7:0] addrSum;

    // Register add and address add are the same 8-bit wrap-around sum.
    assign regSum   = val1 + val2;
    assign addrSum  = val1 + val2;
    assign result   = aluOp ? regSum : addrSum;

    assign readData = MemRead ? mem[result] : 8'h00;

    // Reset loads an identity pattern and wins over any concurrent write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'(i);
            end
        end else if (MemWrite) begin
            mem[result] <= writeData;
        end
    end

    // Segments ordered a..g on bits 6..0, active-high.
    always_comb begin
        seg = 7'b0000000;
        unique case (opcode)
            2'b00: seg = 7'b1110111;
            2'b01: seg = 7'b0001110;
            2'b10: seg = 7'b1011011;
            2'b11: seg = 7'b0111000;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: tb/tb_alu_dmem_opseg.sv
// Directed bench for alu_dmem_opseg: hand-computed vectors checked with
// immediate assertions.
module tb_alu_dmem_opseg;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] val1;
    logic [7:0] val2;
    logic       aluOp;
    logic [7:0] writeData;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] opcode;
    logic [7:0] result;
    logic [7:0] readData;
    logic [6:0] seg;

    int compared   = 0;
    int mismatched = 0;

    alu_dmem_opseg dut (
        .CLK       (CLK),
        .RST       (RST),
        .val1      (val1),
        .val2      (val2),
        .aluOp     (aluOp),
        .writeData (writeData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .opcode    (opcode),
        .result    (result),
        .readData  (readData),
        .seg       (seg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; val1 = 8'h00; val2 = 8'h00; aluOp = 1'b1;
        writeData = 8'h00; MemRead = 1'b0; MemWrite = 1'b0; opcode = 2'b00;
        tick();
        RST = 1'b0;

        // ALU add with carry dropped, both aluOp values
        val1 = 8'h05; val2 = 8'h03; aluOp = 1'b1; #1;
        check("add_5_3", result, 8'h08);
        val1 = 8'hFF; val2 = 8'h02; #1;
        check("add_carry", result, 8'h01);
        aluOp = 1'b0; #1;
        check("addr_add_carry", result, 8'h01);
        val1 = 8'h80; val2 = 8'h80; #1;
        check("addr_add_wrap0", result, 8'h00);

        // Reset contents: identity pattern, reached through a wrapping address
        val1 = 8'h10; val2 = 8'hFF; MemRead = 1'b1; #1;
        check("rst_result", result, 8'h0F);
        check("rst_read_0F", readData, 8'h0F);
        val1 = 8'hFF; val2 = 8'h00; #1;
        check("rst_read_FF", readData, 8'hFF);

        // Write then read, and read disable
        val1 = 8'h20; val2 = 8'h00; writeData = 8'hA5; MemWrite = 1'b1; MemRead = 1'b0;
        tick();
        MemWrite = 1'b0; MemRead = 1'b1; #1;
        check("wr_rd_20", readData, 8'hA5);
        MemRead = 1'b0; #1;
        check("rd_disabled", readData, 8'h00);

        // Retention with MemWrite low
        MemRead = 1'b1; writeData = 8'h3C;
        tick();
        check("retain_20", readData, 8'hA5);

        // Simultaneous read/write: old data before the edge, new after
        val1 = 8'h30; writeData = 8'h77; MemWrite = 1'b1; MemRead = 1'b1; #1;
        check("rw_before", readData, 8'h30);
        tick();
        check("rw_after", readData, 8'h77);
        MemWrite = 1'b0;

        // Reset overrides concurrent write and discards earlier writes
        val1 = 8'h40; writeData = 8'h5A; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0; #1;
        check("wr_40", readData, 8'h5A);
        RST = 1'b1; MemWrite = 1'b1; writeData = 8'h99; #1;
        check("rst_comb_read_pre", readData, 8'h5A);
        tick();
        check("rst_prio_40", readData, 8'h40);
        MemWrite = 1'b0;
        val1 = 8'h20; #1;
        check("rst_clears_20", readData, 8'h20);
        val1 = 8'h30; #1;
        check("rst_clears_30", readData, 8'h30);
        RST = 1'b0;

        // Opcode glyphs, with and without reset asserted
        for (int r = 0; r < 2; r++) begin
            RST = r[0];
            opcode = 2'b00; #1; check("seg_add", {1'b0, seg}, 8'b01110111);
            opcode = 2'b01; #1; check("seg_lw",  {1'b0, seg}, 8'b00001110);
            opcode = 2'b10; #1; check("seg_sw",  {1'b0, seg}, 8'b01011011);
            opcode = 2'b11; #1; check("seg_j",   {1'b0, seg}, 8'b00111000);
        end
        RST = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
